seq_restoring_divider: RTL
==========================

// Module: seq_restoring_divider
// PURPOSE
//   Multi-cycle unsigned restoring divider: Q = A / B, R = A % B.
//   Inverse operation to the combinational add/subtract datapath: each iteration is one shift + trial subtract.
//   Sits beside the adder/subtractor in the lab ALU; start/done handshake toward the controlling FSM.
// PARAMETERS
//   N  4  operand width in bits (dividend, divisor, quotient, remainder); N >= 2
// PORTS
//   clk           in   1  single clock, rising edge
//   rst_n         in   1  asynchronous, active-low reset
//   start         in   1  request; sampled only when busy==0
//   A             in   N  dividend, sampled with accepted start
//   B             in   N  divisor, sampled with accepted start
//   busy          out  1  high while an operation is in progress
//   done          out  1  one-cycle pulse: Q/R/div_by_zero valid
//   Q             out  N  quotient, held until next accepted start
//   R             out  N  remainder, held until next accepted start
//   div_by_zero   out  1  set with done when B==0, held like Q/R
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; busy=0, done=0, Q=0, R=0, div_by_zero=0; iteration count=0.
//   States:
//   - IDLE: start=1 -> latch A,B.
//     - B!=0: clear R, load Q<=A, count<=N, go RUN.
//     - B==0: go DONE directly.
//   - RUN: one iteration per cycle, for N cycles.
//     - shift {R,Q} left 1; T = {1'b0,R_shifted} - {1'b0,B} in N+1 bits.
//     - T MSB==0: R<=T[N-1:0], Q LSB<=1. Otherwise restore (keep R_shifted), Q LSB<=0.
//     - count decrements; at count==1 go DONE.
//   - DONE: done=1 for exactly this one cycle, then IDLE.
//     - start=1 here is accepted exactly as in IDLE (back-to-back).
//   Divide-by-zero: Q=all ones (2^N-1), R=A, div_by_zero=1.
//   - Latency: done in the cycle after the accepting edge; no RUN cycles.
//   Outputs:
//   - busy=1 in RUN only. done=1 in DONE only.
//   - div_by_zero cleared on every accepted start.
//   Latency (B!=0): start accepted at edge k -> RUN for edges k+1..k+N -> done high during cycle after edge k+N.
//   start while busy=1: ignored; A/B changes while busy have no effect.
//   Q/R are intermediate values during RUN; consumers must sample only on done.
//   rst_n asserted mid-RUN: operation aborted immediately; outputs return to reset values; no done pulse.
//   Widths: trial subtract is N+1 bits; no other carries; all values unsigned.
// TESTING (N=4)
//   1. A=13, B=4, start 1 cycle -> busy 4 cycles; done on cycle 5 after start; Q=3, R=1, div_by_zero=0.
//   2. A=15, B=1 -> Q=15, R=0. A=3, B=9 -> Q=0, R=3. A=0, B=5 -> Q=0, R=0.
//   3. A=7, B=0 -> done 1 cycle after start, busy never high; Q=15, R=7, div_by_zero=1.
//   4. start held high throughout with A=9, B=2 then A=14, B=3 -> first result Q=4, R=1.
//      - start in the DONE cycle is accepted, giving the next result Q=4, R=2.
//      - starts during busy are ignored.
//   5. rst_n low 2 cycles after start of A=12, B=5 -> busy, done, Q, R, div_by_zero all 0 asynchronously.
//      - after release, new start A=12, B=5 -> Q=2, R=2.
//   6. Exhaustive: all A,B in 0..15 -> Q=A/B, R=A%B; B=0 cases per divide-by-zero rule.
//      - done is exactly one cycle wide for every run.

Source files
------------

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: Q = A / B, R = A % B.
// One shift plus trial subtract per clock, N iterations per operation.
// A start/done handshake connects it to the controlling FSM. A zero divisor
// finishes in a single cycle: Q is all ones, R is A and div_by_zero is set.
module seq_restoring_divider #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] Q,
    output logic [N-1:0] R,
    output logic         div_by_zero
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q;
    logic [N-1:0]  q_q;
    logic [N-1:0]  r_q;
    logic [N-1:0]  b_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q;
    logic          done_q;
    logic          dbz_q;

    logic [N-1:0]  r_shift_d;
    logic [N:0]    trial_d;

    // One iteration's datapath: shift {R,Q} left by one, then trial-subtract
    // the divisor in N+1 bits. The partial remainder is below 2^(N-1)
    // whenever a shift happens, so R's MSB is never lost.
    always_comb begin
        r_shift_d = {r_q[N-2:0], q_q[N-1]};
        trial_d   = {1'b0, r_shift_d} - {1'b0, b_q};
    end

    // Control FSM and datapath registers; all outputs come straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            r_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            case (state_q)
                // IDLE and DONE both accept a new request (back-to-back issue).
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (start) begin
                        b_q <= B;
                        if (B != '0) begin
                            r_q     <= '0;
                            q_q     <= A;
                            cnt_q   <= CW'(N);
                            dbz_q   <= 1'b0;
                            busy_q  <= 1'b1;
                            state_q <= S_RUN;
                        end else begin
                            q_q     <= '1;
                            r_q     <= A;
                            dbz_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end

                S_RUN: begin
                    // A negative trial result restores the shifted remainder.
                    if (trial_d[N]) begin
                        r_q <= r_shift_d;
                    end else begin
                        r_q <= trial_d[N-1:0];
                    end
                    q_q   <= {q_q[N-2:0], ~trial_d[N]};
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end

                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign Q           = q_q;
    assign R           = r_q;
    assign div_by_zero = dbz_q;

endmodule
